// File: rtl/ps2_pkg.sv
// Shared PS/2 constants, key-event layout and receiver state encoding.
package ps2_pkg;

  localparam logic [7:0] PS2_PREFIX_EXT = 8'hE0;
  localparam logic [7:0] PS2_PREFIX_BRK = 8'hF0;
  localparam int unsigned KEY_EVENT_W   = 10;

  // Queued key event: rel at bit 9, ext at bit 8, scan code below.
  typedef struct packed {
    logic       rel;
    logic       ext;
    logic [7:0] code;
  } key_event_t;

  typedef enum logic [1:0] {StIdle, StData, StParity, StStop} rx_state_e;

endpackage

// File: rtl/ps2_key_buffer_if.sv
// CPU-side bus of the key buffer: read strobe, head entry and status.
interface ps2_key_buffer_if #(
  parameter int unsigned DEPTH = 16
) ();
  import ps2_pkg::*;

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                   raw_mode;
  logic                   rd;
  logic                   ovf_clr;
  logic [KEY_EVENT_W-1:0] rd_data;
  logic                   empty;
  logic [CW-1:0]          count;
  logic                   irq;
  logic                   overflow;

  modport master (
    output raw_mode, rd, ovf_clr,
    input  rd_data, empty, count, irq, overflow
  );

  modport slave (
    input  raw_mode, rd, ovf_clr,
    output rd_data, empty, count, irq, overflow
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: pin synchroniser, ps2_clk glitch filter, idle timeout
// and start/data/parity/stop framing.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);

  localparam int unsigned FW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          filt_q;
  logic [FW-1:0] filt_cnt_q;
  logic [TW-1:0] tmo_q;
  rx_state_e     state_q;
  logic [2:0]    bit_cnt_q;
  logic [7:0]    shift_q;
  logic          parity_q;

  logic clk_s, data_s, edge_any, edge_fall, expired;

  assign clk_s     = clk_sync_q[1];
  assign data_s    = data_sync_q[1];
  // A level change is accepted on the FILTER_LEN-th consecutive differing sample.
  assign edge_any  = (clk_s != filt_q) && (filt_cnt_q == FW'(FILTER_LEN - 1));
  assign edge_fall = edge_any && filt_q;
  assign expired   = (tmo_q == TW'(TIMEOUT - 1)) && !edge_any;

  // Two-flop synchronisers for both pins; idle level is high.
  always_ff @(posedge clk) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2_clk};
      data_sync_q <= {data_sync_q[0], ps2_data};
    end
  end

  // ps2_clk filter and edge-to-edge timeout counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      filt_q     <= 1'b1;
      filt_cnt_q <= '0;
      tmo_q      <= '0;
    end else begin
      if (clk_s == filt_q) begin
        filt_cnt_q <= '0;
      end else if (edge_any) begin
        filt_q     <= clk_s;
        filt_cnt_q <= '0;
      end else begin
        filt_cnt_q <= filt_cnt_q + 1'b1;
      end
      if (edge_any) begin
        tmo_q <= '0;
      end else if (tmo_q != TW'(TIMEOUT - 1)) begin
        tmo_q <= tmo_q + 1'b1;
      end
    end
  end

  // Frame FSM, sampling data on filtered falling edges; outputs registered.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (expired && state_q != StIdle) begin
        state_q <= StIdle;
      end else if (edge_fall) begin
        unique case (state_q)
          StIdle: begin
            if (!data_s) begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
          StData: begin
            shift_q   <= {data_s, shift_q[7:1]};
            bit_cnt_q <= bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_q <= StParity;
          end
          StParity: begin
            parity_q <= data_s;
            state_q  <= StStop;
          end
          StStop: begin
            state_q <= StIdle;
            if (data_s && (^{shift_q, parity_q})) begin
              rx_byte    <= shift_q;
              byte_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_buffer.sv
// PS/2 key-event buffer: prefix decoder feeding a first-word-fall-through FIFO.
module ps2_key_buffer
  import ps2_pkg::*;
#(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned FILTER_LEN = 8,
  parameter int unsigned TIMEOUT    = 50000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    ps2_clk,
  input  logic                    ps2_data,
  ps2_key_buffer_if.slave         bus
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [7:0] rx_byte;
  logic       byte_valid;
  logic       unused_frame_err;

  ps2_rx #(
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_rx (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .rx_byte    (rx_byte),
    .byte_valid (byte_valid),
    .frame_err  (unused_frame_err)
  );

  logic       ext_q, rel_q, raw_q, push_q;
  key_event_t push_data_q;

  // Prefix decoder; a raw_mode change drops any pending prefix.
  always_ff @(posedge clk) begin
    if (reset) begin
      ext_q       <= 1'b0;
      rel_q       <= 1'b0;
      raw_q       <= 1'b0;
      push_q      <= 1'b0;
      push_data_q <= '0;
    end else begin
      push_q <= 1'b0;
      raw_q  <= bus.raw_mode;
      if (byte_valid) begin
        if (bus.raw_mode) begin
          push_q      <= 1'b1;
          push_data_q <= '{rel: 1'b0, ext: 1'b0, code: rx_byte};
        end else if (rx_byte == PS2_PREFIX_EXT) begin
          ext_q <= 1'b1;
        end else if (rx_byte == PS2_PREFIX_BRK) begin
          rel_q <= 1'b1;
        end else begin
          push_q      <= 1'b1;
          push_data_q <= '{rel: rel_q, ext: ext_q, code: rx_byte};
          ext_q       <= 1'b0;
          rel_q       <= 1'b0;
        end
      end
      if (bus.raw_mode != raw_q) begin
        ext_q <= 1'b0;
        rel_q <= 1'b0;
      end
    end
  end

  key_event_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          ovf_q;
  logic          is_empty, is_full, pop, accept, drop;

  assign is_empty = (count_q == '0);
  assign is_full  = (count_q == CW'(DEPTH));
  assign pop      = bus.rd && !is_empty;
  // Pop frees the head slot this cycle, so a push on full with pop is accepted.
  assign accept   = push_q && (!is_full || pop);
  assign drop     = push_q && is_full && !pop;

  // FIFO storage, pointers, occupancy and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      if (accept) begin
        mem[wr_ptr_q] <= push_data_q;
        wr_ptr_q      <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      if (accept && !pop) begin
        count_q <= count_q + 1'b1;
      end else if (!accept && pop) begin
        count_q <= count_q - 1'b1;
      end
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (bus.ovf_clr) begin
        ovf_q <= 1'b0;
      end
    end
  end

  // Head entry falls through; forced to zero when empty.
  always_comb begin
    bus.rd_data  = is_empty ? '0 : mem[rd_ptr_q];
    bus.empty    = is_empty;
    bus.irq      = !is_empty;
    bus.count    = count_q;
    bus.overflow = ovf_q;
  end

endmodule

// File: tb/tb_ps2_key_buffer.sv
// Directed bench for ps2_key_buffer with shortened filter/timeout and DEPTH 4.
module tb_ps2_key_buffer;

  localparam int unsigned DEPTH      = 4;
  localparam int unsigned FILTER_LEN = 4;
  localparam int unsigned TIMEOUT    = 400;
  localparam int unsigned HALF       = 20;

  logic clk = 1'b0;
  logic reset;
  logic ps2_clk, ps2_data;
  int   checks = 0;
  int   errors = 0;

  ps2_key_buffer_if #(.DEPTH(DEPTH)) bus ();

  ps2_key_buffer #(
    .DEPTH      (DEPTH),
    .FILTER_LEN (FILTER_LEN),
    .TIMEOUT    (TIMEOUT)
  ) u_dut (
    .clk      (clk),
    .reset    (reset),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One device-driven bit: data set while ps2_clk high, sampled on the fall.
  task automatic send_bit(input logic b, input bit pop_sync);
    ps2_data = b;
    wait_cycles(HALF);
    ps2_clk = 1'b0;
    if (pop_sync) begin
      int n = 0;
      while (u_dut.push_q !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      if (n >= 100) begin
        checks++;
        errors++;
        $error("FAIL push_wait observed timeout expected push");
      end else begin
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
      end
    end
    wait_cycles(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit pop_sync);
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i], 1'b0);
    send_bit((~^b) ^ bad_par, 1'b0);
    send_bit(1'b1, pop_sync);
    ps2_data = 1'b1;
    wait_cycles(30);
  endtask

  task automatic pop1();
    bus.rd = 1'b1;
    @(negedge clk);
    bus.rd = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset        = 1'b1;
    ps2_clk      = 1'b1;
    ps2_data     = 1'b1;
    bus.rd       = 1'b0;
    bus.ovf_clr  = 1'b0;
    bus.raw_mode = 1'b0;
    wait_cycles(5);
    reset = 1'b0;
    wait_cycles(2);

    chk("rst_empty", 32'(bus.empty), 1);
    chk("rst_irq", 32'(bus.irq), 0);
    chk("rst_count", 32'(bus.count), 0);
    chk("rst_rd_data", 32'(bus.rd_data), 0);
    chk("rst_ovf", 32'(bus.overflow), 0);

    // Make and break of 0x1C.
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("make_irq", 32'(bus.irq), 1);
    chk("make_data", 32'(bus.rd_data), 32'h01C);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("brk_count", 32'(bus.count), 2);
    pop1();
    chk("brk_data", 32'(bus.rd_data), 32'h21C);
    pop1();
    chk("drain_empty", 32'(bus.empty), 1);
    chk("drain_data", 32'(bus.rd_data), 0);
    pop1();
    chk("rd_on_empty", 32'(bus.count), 0);

    // Extended make and extended break.
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("ext_count", 32'(bus.count), 2);
    chk("ext_make", 32'(bus.rd_data), 32'h175);
    pop1();
    chk("ext_brk", 32'(bus.rd_data), 32'h375);
    pop1();

    // Bad parity is dropped.
    send_frame(8'h1C, 1'b1, 1'b0);
    chk("badpar_count", 32'(bus.count), 0);
    send_frame(8'h32, 1'b0, 1'b0);
    chk("after_bad_count", 32'(bus.count), 1);
    chk("after_bad_data", 32'(bus.rd_data), 32'h032);
    pop1();

    // Half frame abandoned by the timeout.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    ps2_data = 1'b1;
    wait_cycles(TIMEOUT + 200);
    send_frame(8'h2B, 1'b0, 1'b0);
    chk("tmo_count", 32'(bus.count), 1);
    chk("tmo_data", 32'(bus.rd_data), 32'h02B);
    pop1();

    // DEPTH+1 keys with no reads.
    for (int k = 1; k <= DEPTH + 1; k++) send_frame(8'(k), 1'b0, 1'b0);
    chk("full_count", 32'(bus.count), DEPTH);
    chk("full_ovf", 32'(bus.overflow), 1);
    chk("full_head", 32'(bus.rd_data), 32'h001);
    bus.ovf_clr = 1'b1;
    @(negedge clk);
    bus.ovf_clr = 1'b0;
    chk("ovf_clr", 32'(bus.overflow), 0);

    // Full FIFO with a read coincident with the push.
    send_frame(8'h06, 1'b0, 1'b1);
    chk("fullrw_count", 32'(bus.count), DEPTH);
    chk("fullrw_ovf", 32'(bus.overflow), 0);
    for (int k = 2; k <= DEPTH; k++) begin
      chk("fullrw_entry", 32'(bus.rd_data), 32'(k));
      pop1();
    end
    chk("fullrw_tail", 32'(bus.rd_data), 32'h006);
    pop1();
    chk("fullrw_empty", 32'(bus.empty), 1);

    // Raw mode queues prefixes verbatim.
    bus.raw_mode = 1'b1;
    wait_cycles(2);
    send_frame(8'hE0, 1'b0, 1'b0);
    send_frame(8'hF0, 1'b0, 1'b0);
    send_frame(8'h75, 1'b0, 1'b0);
    chk("raw_count", 32'(bus.count), 3);
    chk("raw_e0", 32'(bus.rd_data), 32'h0E0);
    pop1();
    chk("raw_f0", 32'(bus.rd_data), 32'h0F0);
    bus.raw_mode = 1'b0;
    wait_cycles(2);

    // Reset between data bits 3 and 4 of a frame.
    send_bit(1'b0, 1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b0, 1'b0);
    reset = 1'b1;
    wait_cycles(3);
    reset = 1'b0;
    ps2_data = 1'b1;
    wait_cycles(2);
    chk("midrst_empty", 32'(bus.empty), 1);
    chk("midrst_count", 32'(bus.count), 0);
    wait_cycles(50);
    send_frame(8'h1C, 1'b0, 1'b0);
    chk("post_rst_count", 32'(bus.count), 1);
    chk("post_rst_data", 32'(bus.rd_data), 32'h01C);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
